// File: rtl/execute_mc.sv
// Execute stage: single-cycle ALU ops plus a bit-serial shift-add multiplier.
// All three result buses and zero_E are registered and published together.
module execute_mc #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         valid_in,
  input  logic         AluSrc,
  input  logic [3:0]   AluControl,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  output logic [N-1:0] PCBranch_E,
  output logic [N-1:0] aluResult_E,
  output logic [N-1:0] writeData_E,
  output logic         zero_E,
  output logic         valid_out,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   acc_q, mcand_q, mplier_q;
  logic [N-1:0]   pcb_pend_q, wd_pend_q;
  logic [N-1:0]   pcb_q, res_q, wd_q;
  logic           zero_q, vout_q;

  logic [N-1:0]   op_b, alu_d, pcb_d;
  logic           is_mul;

  assign op_b   = AluSrc ? signImm_E : readData2_E;
  assign pcb_d  = PC_E + (signImm_E << 2);
  assign is_mul = (AluControl == OP_MUL);

  always_comb begin
    alu_d = '0;
    case (AluControl)
      OP_AND:  alu_d = readData1_E & op_b;
      OP_OR:   alu_d = readData1_E | op_b;
      OP_ADD:  alu_d = readData1_E + op_b;
      OP_SUB:  alu_d = readData1_E - op_b;
      OP_PASS: alu_d = op_b;
      default: alu_d = '0;
    endcase
  end

  // MUL runs N shift-add iterations, then spends one more edge publishing the
  // product, so results appear N+1 edges after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      pcb_pend_q <= '0;
      wd_pend_q  <= '0;
      pcb_q      <= '0;
      res_q      <= '0;
      wd_q       <= '0;
      zero_q     <= 1'b0;
      vout_q     <= 1'b0;
    end else begin
      vout_q <= 1'b0;
      if (flush) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        acc_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (valid_in) begin
              if (is_mul) begin
                state_q    <= S_MUL;
                cnt_q      <= '0;
                acc_q      <= '0;
                mcand_q    <= readData1_E;
                mplier_q   <= op_b;
                pcb_pend_q <= pcb_d;
                wd_pend_q  <= readData2_E;
              end else begin
                res_q  <= alu_d;
                zero_q <= (alu_d == '0);
                pcb_q  <= pcb_d;
                wd_q   <= readData2_E;
                vout_q <= 1'b1;
              end
            end
          end
          S_MUL: begin
            if (cnt_q != CNT_DONE) begin
              if (mplier_q[0]) acc_q <= acc_q + mcand_q;
              mcand_q  <= mcand_q << 1;
              mplier_q <= mplier_q >> 1;
              cnt_q    <= cnt_q + CNT_ONE;
            end else begin
              res_q   <= acc_q;
              zero_q  <= (acc_q == '0);
              pcb_q   <= pcb_pend_q;
              wd_q    <= wd_pend_q;
              vout_q  <= 1'b1;
              state_q <= S_IDLE;
              cnt_q   <= '0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy        = (state_q == S_MUL);
  assign PCBranch_E  = pcb_q;
  assign aluResult_E = res_q;
  assign writeData_E = wd_q;
  assign zero_E      = zero_q;
  assign valid_out   = vout_q;

endmodule

// File: tb/tb_execute_mc.sv
// Directed bench for execute_mc (N=64): ALU ops, MUL timing, stall, flush, reset.
module tb_execute_mc;
  localparam int N = 64;

  logic         clk, reset, flush, valid_in, AluSrc;
  logic [3:0]   AluControl;
  logic [N-1:0] PC_E, signImm_E, readData1_E, readData2_E;
  logic [N-1:0] PCBranch_E, aluResult_E, writeData_E;
  logic         zero_E, valid_out, busy;

  int tests, fails;

  execute_mc #(.N(N)) dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in),
    .AluSrc(AluSrc), .AluControl(AluControl), .PC_E(PC_E),
    .signImm_E(signImm_E), .readData1_E(readData1_E), .readData2_E(readData2_E),
    .PCBranch_E(PCBranch_E), .aluResult_E(aluResult_E), .writeData_E(writeData_E),
    .zero_E(zero_E), .valid_out(valid_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ctl, input logic src, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] imm, input logic [63:0] pc);
    valid_in    = 1'b1;
    AluControl  = ctl;
    AluSrc      = src;
    readData1_E = a;
    readData2_E = b;
    signImm_E   = imm;
    PC_E        = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int  bcnt, guard;
  logic vseen, held;

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0; AluSrc = 1'b0; AluControl = '0;
    PC_E = '0; signImm_E = '0; readData1_E = '0; readData2_E = '0;
    #3;
    chk("rst_res",  aluResult_E, 64'd0);
    chk("rst_pcb",  PCBranch_E, 64'd0);
    chk("rst_wd",   writeData_E, 64'd0);
    chk("rst_zero", zero_E, 64'd0);
    chk("rst_vld",  valid_out, 64'd0);
    chk("rst_busy", busy, 64'd0);
    step();
    reset = 1'b0;

    // ADD 5+7
    drive(4'b0010, 1'b0, 64'd5, 64'd7, 64'd4, 64'h100);
    step();
    valid_in = 1'b0;
    chk("add_res",  aluResult_E, 64'd12);
    chk("add_zero", zero_E, 64'd0);
    chk("add_pcb",  PCBranch_E, 64'h110);
    chk("add_wd",   writeData_E, 64'd7);
    chk("add_vld",  valid_out, 64'd1);
    step();
    chk("add_vld_drop", valid_out, 64'd0);

    // SUB 9-9
    drive(4'b0110, 1'b0, 64'd9, 64'd9, 64'd0, 64'd0);
    step();
    valid_in = 1'b0;
    chk("sub_res",  aluResult_E, 64'd0);
    chk("sub_zero", zero_E, 64'd1);

    // Unknown code yields 0
    drive(4'b0011, 1'b0, 64'd9, 64'd3, 64'd0, 64'd0);
    step();
    chk("unk_res", aluResult_E, 64'd0);

    // Pass B via immediate
    drive(4'b0111, 1'b1, 64'd1, 64'd2, 64'h1234, 64'd0);
    step();
    chk("pass_res",  aluResult_E, 64'h1234);
    chk("pass_zero", zero_E, 64'd0);

    // ADD wrap with immediate
    drive(4'b0010, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h55, 64'd1, 64'd0);
    step();
    valid_in = 1'b0;
    chk("wrap_res",  aluResult_E, 64'd0);
    chk("wrap_zero", zero_E, 64'd1);
    chk("wrap_pcb",  PCBranch_E, 64'd4);
    chk("wrap_wd",   writeData_E, 64'h55);

    // flush blocks acceptance of a single-cycle op
    drive(4'b0010, 1'b0, 64'd1, 64'd1, 64'd0, 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0; valid_in = 1'b0;
    chk("flushacc_vld", valid_out, 64'd0);
    chk("flushacc_res", aluResult_E, 64'd0);

    // MUL with valid_in held high and different data while busy
    drive(4'b1000, 1'b0, 64'h1_0000_0003, 64'h1_0000_0005, 64'd1, 64'h200);
    step();
    drive(4'b0010, 1'b0, 64'd1, 64'd1, 64'd0, 64'd0);
    bcnt = 0; guard = 0; vseen = 1'b0; held = 1'b1;
    while (busy === 1'b1 && guard < 200) begin
      bcnt++; guard++;
      if (valid_out !== 1'b0) vseen = 1'b1;
      if (aluResult_E !== 64'd0 || zero_E !== 1'b1) held = 1'b1 & 1'b0;
      step();
    end
    chk("mul_busy_cycles", bcnt, 64'd65);
    chk("mul_no_early_vld", vseen, 64'd0);
    chk("mul_hold", held, 64'd1);
    chk("mul_vld",  valid_out, 64'd1);
    chk("mul_res",  aluResult_E, 64'h8_0000_000F);
    chk("mul_zero", zero_E, 64'd0);
    chk("mul_pcb",  PCBranch_E, 64'h204);
    chk("mul_wd",   writeData_E, 64'h1_0000_0005);
    // Back-to-back ADD accepted in the valid_out cycle
    drive(4'b0010, 1'b0, 64'd3, 64'd4, 64'd0, 64'd0);
    step();
    valid_in = 1'b0;
    chk("b2b_res", aluResult_E, 64'd7);
    chk("b2b_vld", valid_out, 64'd1);
    chk("b2b_busy", busy, 64'd0);
    step();
    chk("b2b_vld_drop", valid_out, 64'd0);

    // MUL flushed at iteration 30
    drive(4'b1000, 1'b0, 64'd3, 64'd5, 64'd0, 64'd0);
    step();
    valid_in = 1'b0;
    chk("fl_busy_start", busy, 64'd1);
    for (int i = 0; i < 29; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_busy", busy, 64'd0);
    chk("fl_vld",  valid_out, 64'd0);
    chk("fl_res",  aluResult_E, 64'd7);
    vseen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (valid_out !== 1'b0 || busy !== 1'b0) vseen = 1'b1;
      step();
    end
    chk("fl_quiet", vseen, 64'd0);
    chk("fl_res_hold", aluResult_E, 64'd7);
    drive(4'b0000, 1'b0, 64'hF0, 64'h3C, 64'd0, 64'd0);
    step();
    valid_in = 1'b0;
    chk("and_res", aluResult_E, 64'h30);
    chk("and_vld", valid_out, 64'd1);

    // Reset mid-MUL
    drive(4'b1000, 1'b0, 64'd6, 64'd7, 64'd2, 64'h40);
    step();
    valid_in = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("rmid_busy_pre", busy, 64'd1);
    reset = 1'b1;
    #1;
    chk("rmid_res",  aluResult_E, 64'd0);
    chk("rmid_pcb",  PCBranch_E, 64'd0);
    chk("rmid_busy", busy, 64'd0);
    chk("rmid_vld",  valid_out, 64'd0);
    step();
    reset = 1'b0;
    vseen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (valid_out !== 1'b0 || busy !== 1'b0) vseen = 1'b1;
      step();
    end
    chk("rmid_quiet", vseen, 64'd0);
    drive(4'b0001, 1'b0, 64'hA0, 64'h0B, 64'd0, 64'd0);
    step();
    valid_in = 1'b0;
    chk("or_res", aluResult_E, 64'hAB);
    chk("or_vld", valid_out, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
